suma_mult_seq: RTL and testbench
================================

# suma_mult_seq

Self-sequenced, parametrised generalisation of the sum-of-multiples datapath. Given a limit `n` and two runtime-programmable factors `fa`, `fb`, it computes the sum of all integers `1 <= i < n` divisible by `fa` or `fb`, each counted once. It has an internal FSM and a start/done handshake, so no external controller is needed. Operand, factor and accumulator widths are parameters; arithmetic wrap is reported through a sticky overflow flag.

## Interface
- `NW`, 16, width of `n` and of the internal index/term counters
- `FW`, 8, width of `fa`, `fb` and of the residue counters
- `AW`, 32, width of the `sum` accumulator
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `start`  in  1  request a computation; sampled on a clock edge, honoured only in IDLE or FIN
- `n`  in  NW  exclusive upper limit; latched when `start` is accepted
- `fa`  in  FW  first factor, latched on accept; 0 disables this factor
- `fb`  in  FW  second factor, latched on accept; 0 disables this factor
- `busy`  out  1  high while in RUN
- `done`  out  1  one-cycle pulse, high in FIN
- `sum`  out  AW  result accumulator
- `count`  out  NW  number of terms added
- `overflow`  out  1  sticky; set when any addition carries out of AW bits

## Operation
- States: IDLE, RUN, FIN.
  - IDLE --start--> RUN.
  - RUN --(i >= n_l)--> FIN.
  - FIN --start--> RUN; otherwise FIN --> IDLE.
- `start` in RUN is ignored. `n`, `fa`, `fb` are don't-care except at the accepting edge.
- On accept, all of the following happen on the same edge:
  - latch `n_l`, `fa_l`, `fb_l`;
  - set `i` = 1;
  - set `ra` = `fa`-1 and `rb` = `fb`-1 (each only if the factor is non-zero);
  - clear `sum`, `count` and `overflow`.
- Each RUN cycle with `i < n_l`:
  - `hit` = (`fa_l` != 0 and `ra` == 0) or (`fb_l` != 0 and `rb` == 0);
  - if `hit`: `sum` += `i` (zero-extended, modulo 2^AW), `count` += 1, and `overflow` is set if the add carries out;
  - each enabled residue counter reloads to factor-1 at 0 and otherwise decrements;
  - `i` += 1.
- No multiply or divide is used; divisibility comes only from the residue counters.
- Common multiples (e.g. 15 with 3/5) are added once. If `fa` == `fb`, terms are not double-counted.
- Factor 1 selects every integer. If both factors are 0, the run completes with `sum` = 0 and `count` = 0.
- `sum`, `count` and `overflow` hold their values after FIN until the next accepted `start`.
- Reset (asynchronous, at any time including mid-RUN) forces IDLE and drives `busy`, `done`, `sum`, `count`, `overflow` and all internal registers to 0. The first accept after reset behaves normally.

## Timing
- Accept edge E0. The edges that process `i` = 1..`n`-1 are E1..E(`n`-1). Edge E(max(`n`,1)) enters FIN, so `done` is high during the cycle after it.
- Start-to-done latency is max(`n`,1) clock edges. `n` = 0 and `n` = 1 both give `done` one cycle after accept.
- `busy` is high from E0 up to the edge that enters FIN, and low in FIN.
- Outputs are registered. In the FIN cycle, `sum`/`count`/`overflow` already hold their final values.
- Back-to-back operation: `start` held high during FIN restarts with no IDLE gap. `done` then pulses once per run.
- `start` held continuously high gives one run per max(`n`,1)+1 cycles.

## Test plan
- `n`=10, `fa`=3, `fb`=5 -> `sum`=23, `count`=4, `done` exactly 10 cycles after accept, `busy` high 10 cycles, `overflow`=0.
- `n`=1000, `fa`=3, `fb`=5 -> `sum`=233168, `count`=466; immediate restart in FIN with `n`=16, `fa`=3, `fb`=0 -> `sum`=45, `count`=5.
- `n`=0, then `n`=1 (`fa`=3, `fb`=5); and `n`=20, `fa`=`fb`=0 -> each gives `sum`=0 and `count`=0; the `n`=0 and `n`=1 cases pulse `done` 1 cycle after accept.
- AW=8 instance, `n`=30, `fa`=1, `fb`=0 -> `sum`=179 (435 mod 256), `count`=29, `overflow`=1; the next run with `n`=5, `fa`=2 -> `sum`=6, `overflow`=0.
- `start` pulsed mid-RUN with different `n` -> ignored, the result matches the original operands; `fa`=`fb`=4, `n`=13 -> `sum`=24, `count`=3.
- `rst_n` low mid-RUN (asynchronous, between edges) -> outputs 0 immediately, IDLE, no `done`; a new run after release gives the correct result.

Source files
------------

// File: rtl/suma_mult_seq.sv
// Sum of all 1 <= i < n divisible by fa or fb, using residue counters only (no multiply/divide).
// Latency: done pulses max(n,1) edges after the accepting edge; one run per max(n,1)+1 cycles back-to-back.
// Backpressure: none; start is only honoured in IDLE or FIN, and is ignored while busy.
//
// Ports:
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   start               request a run (accepted in IDLE or FIN)
//   n, fa, fb           exclusive limit and the two factors (0 disables a factor), latched on accept
//   busy, done          busy in RUN, one-cycle done pulse in FIN
//   sum, count          accumulated result and number of terms added
//   overflow            sticky carry-out of the AW-bit accumulator for the current run
module suma_mult_seq #(
   parameter int NW = 16,
   parameter int FW = 8,
   parameter int AW = 32
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic [NW-1:0] n,
   input  logic [FW-1:0] fa,
   input  logic [FW-1:0] fb,
   output logic          busy,
   output logic          done,
   output logic [AW-1:0] sum,
   output logic [NW-1:0] count,
   output logic          overflow
);

   // Adder is wide enough for both operands plus a carry bit, so any bit
   // at or above AW means the AW-bit accumulator wrapped.
   localparam int XW = ((AW > NW) ? AW : NW) + 1;

   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIN = 2'd2} state_t;

   state_t        state;
   state_t        state_nx;

   logic [NW-1:0] n_l;
   logic [FW-1:0] fa_l;
   logic [FW-1:0] fb_l;
   logic [NW-1:0] i;
   logic [FW-1:0] ra;
   logic [FW-1:0] rb;

   logic          accept;
   logic          last;
   logic          hit;
   logic [XW-1:0] add_w;

   assign accept = start && ((state == IDLE) || (state == FIN));
   assign last   = (i >= n_l);
   // A zero residue marks i as a multiple of that factor; disabled factors never hit.
   assign hit    = ((fa_l != '0) && (ra == '0)) || ((fb_l != '0) && (rb == '0));
   assign add_w  = XW'(sum) + XW'(i);

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Next-state logic
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (start) state_nx = RUN;
         RUN:     if (last)  state_nx = FIN;
         FIN:     state_nx = start ? RUN : IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Output decode: both flags come straight from the state register.
   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      case (state)
         RUN:     busy = 1'b1;
         FIN:     done = 1'b1;
         default: ;
      endcase
   end

   // Datapath: operand latches, index, residue counters and accumulator.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         n_l      <= '0;
         fa_l     <= '0;
         fb_l     <= '0;
         i        <= '0;
         ra       <= '0;
         rb       <= '0;
         sum      <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else if (accept) begin
         n_l      <= n;
         fa_l     <= fa;
         fb_l     <= fb;
         i        <= NW'(1);
         ra       <= (fa != '0) ? fa - FW'(1) : '0;
         rb       <= (fb != '0) ? fb - FW'(1) : '0;
         sum      <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else if ((state == RUN) && !last) begin
         if (hit) begin
            sum   <= add_w[AW-1:0];
            count <= count + NW'(1);
            if (|add_w[XW-1:AW]) begin
               overflow <= 1'b1;
            end
         end
         // Each counter cycles factor-1 .. 0, hitting 0 on every multiple.
         if (fa_l != '0) begin
            ra <= (ra == '0) ? fa_l - FW'(1) : ra - FW'(1);
         end
         if (fb_l != '0) begin
            rb <= (rb == '0) ? fb_l - FW'(1) : rb - FW'(1);
         end
         i <= i + NW'(1);
      end
   end

endmodule

// File: tb/tb_suma_mult_seq.sv
module tb_suma_mult_seq;

   logic        clk;
   logic        rst_n;
   logic        start0;
   logic        start8;
   logic [15:0] n;
   logic [7:0]  fa;
   logic [7:0]  fb;

   logic        busy0, done0, ovf0;
   logic [31:0] sum0;
   logic [15:0] count0;
   logic        busy8, done8, ovf8;
   logic [7:0]  sum8;
   logic [15:0] count8;

   int total = 0;
   int bad   = 0;

   suma_mult_seq #(.NW(16), .FW(8), .AW(32)) dut (
      .clk(clk), .rst_n(rst_n), .start(start0), .n(n), .fa(fa), .fb(fb),
      .busy(busy0), .done(done0), .sum(sum0), .count(count0), .overflow(ovf0)
   );

   suma_mult_seq #(.NW(16), .FW(8), .AW(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .start(start8), .n(n), .fa(fa), .fb(fb),
      .busy(busy8), .done(done8), .sum(sum8), .count(count8), .overflow(ovf8)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input longint act, input longint exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", nm, act, exp);
      end
   endtask

   // Reference result straight from the definition, using % freely.
   function automatic void ref_calc(input int nn, input int a, input int b, input int aw,
                                    output longint s, output longint c, output bit o);
      longint t;
      t = 0;
      c = 0;
      for (int k = 1; k < nn; k++) begin
         if ((a != 0 && k % a == 0) || (b != 0 && k % b == 0)) begin
            t += k;
            c++;
         end
      end
      o = (t >= (64'd1 << aw));
      s = t % (64'd1 << aw);
   endfunction

   // Cycle-level model: mode 0 idle, 1 running, 2 finished.
   int     m_mode [2];
   int     m_left [2];
   longint m_sum  [2];
   longint m_cnt  [2];
   bit     m_ovf  [2];

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < 2; k++) begin
            m_mode[k] = 0; m_left[k] = 0; m_sum[k] = 0; m_cnt[k] = 0; m_ovf[k] = 0;
         end
      end else begin
         for (int k = 0; k < 2; k++) begin
            if (m_mode[k] == 1) begin
               m_left[k]--;
               if (m_left[k] == 0) m_mode[k] = 2;
            end else if ((k == 0) ? start0 : start8) begin
               ref_calc(int'(n), int'(fa), int'(fb), (k == 0) ? 32 : 8, m_sum[k], m_cnt[k], m_ovf[k]);
               m_mode[k] = 1;
               m_left[k] = (n == 0) ? 1 : int'(n);
            end else if (m_mode[k] == 2) begin
               m_mode[k] = 0;
            end
         end
      end
   end

   // Every-cycle compare; results are only meaningful outside RUN.
   always @(negedge clk) begin
      chk("cyc busy0", busy0, m_mode[0] == 1);
      chk("cyc done0", done0, m_mode[0] == 2);
      chk("cyc busy8", busy8, m_mode[1] == 1);
      chk("cyc done8", done8, m_mode[1] == 2);
      if (m_mode[0] != 1) begin
         chk("cyc sum0", longint'(sum0), m_sum[0]);
         chk("cyc count0", longint'(count0), m_cnt[0]);
         chk("cyc ovf0", ovf0, m_ovf[0]);
      end
      if (m_mode[1] != 1) begin
         chk("cyc sum8", longint'(sum8), m_sum[1]);
         chk("cyc count8", longint'(count8), m_cnt[1]);
         chk("cyc ovf8", ovf8, m_ovf[1]);
      end
   end

   // Accept a run, wait for done with a bound, then check hand-computed literals.
   // poke: pulse start with other operands a few edges into the run.
   task automatic run(input int k, input int nn, input int a, input int b, input int lat,
                      input longint s, input longint c, input bit o, input bit poke);
      int  cyc;
      int  bcnt;
      bit  seen;
      n  = 16'(nn);
      fa = 8'(a);
      fb = 8'(b);
      if (k == 0) start0 = 1'b1; else start8 = 1'b1;
      @(posedge clk);
      #2;
      start0 = 1'b0;
      start8 = 1'b0;
      cyc  = 0;
      bcnt = (k == 0) ? int'(busy0) : int'(busy8);
      seen = 1'b0;
      while (cyc < lat + 5 && !seen) begin
         @(posedge clk);
         cyc++;
         #1;
         if (poke && cyc == 3) begin
            n = 16'd5; fa = 8'd1; fb = 8'd0; start0 = 1'b1;
         end
         if (poke && cyc == 4) start0 = 1'b0;
         if ((k == 0) ? done0 : done8) seen = 1'b1;
         else bcnt += (k == 0) ? int'(busy0) : int'(busy8);
      end
      chk($sformatf("n=%0d done seen", nn), seen, 1);
      chk($sformatf("n=%0d latency", nn), cyc, lat);
      chk($sformatf("n=%0d busy cycles", nn), bcnt, lat);
      chk($sformatf("n=%0d sum", nn), (k == 0) ? longint'(sum0) : longint'(sum8), s);
      chk($sformatf("n=%0d count", nn), (k == 0) ? longint'(count0) : longint'(count8), c);
      chk($sformatf("n=%0d overflow", nn), (k == 0) ? ovf0 : ovf8, o);
   endtask

   initial begin
      rst_n  = 1'b0;
      start0 = 1'b0;
      start8 = 1'b0;
      n      = '0;
      fa     = '0;
      fb     = '0;
      #1;
      chk("reset busy", busy0, 0);
      chk("reset done", done0, 0);
      chk("reset sum", longint'(sum0), 0);
      chk("reset count", longint'(count0), 0);
      chk("reset ovf", ovf0, 0);
      chk("reset sum8", longint'(sum8), 0);
      #22 rst_n = 1'b1;
      @(posedge clk);
      #2;

      run(0, 10, 3, 5, 10, 23, 4, 0, 0);
      repeat (2) @(posedge clk);
      #2;
      run(0, 1000, 3, 5, 1000, 233168, 466, 0, 0);
      run(0, 16, 3, 0, 16, 45, 5, 0, 0);           // restart straight from FIN
      repeat (2) @(posedge clk);
      #2;
      run(0, 0, 3, 5, 1, 0, 0, 0, 0);
      run(0, 1, 3, 5, 1, 0, 0, 0, 0);
      run(0, 20, 0, 0, 20, 0, 0, 0, 0);
      run(1, 30, 1, 0, 30, 179, 29, 1, 0);
      run(1, 5, 2, 0, 5, 6, 2, 0, 0);
      repeat (1) @(posedge clk);
      #2;
      run(0, 13, 4, 4, 13, 24, 3, 0, 1);          // mid-run start ignored

      // Asynchronous reset between edges in the middle of a run.
      n = 16'd100; fa = 8'd3; fb = 8'd5; start0 = 1'b1;
      @(posedge clk);
      #2;
      start0 = 1'b0;
      repeat (5) @(posedge clk);
      #3;
      chk("pre-reset busy", busy0, 1);
      chk("pre-reset sum", longint'(sum0), 8);
      rst_n = 1'b0;
      #1;
      chk("async rst busy", busy0, 0);
      chk("async rst done", done0, 0);
      chk("async rst sum", longint'(sum0), 0);
      chk("async rst count", longint'(count0), 0);
      chk("async rst ovf", ovf0, 0);
      repeat (2) @(posedge clk);
      #1;
      chk("held rst done", done0, 0);
      #2 rst_n = 1'b1;
      @(posedge clk);
      #2;
      run(0, 10, 3, 5, 10, 23, 4, 0, 0);
      repeat (3) @(posedge clk);
      #2;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
